tx_packet_mux: RTL and testbench
================================

# tx_packet_mux

Parametrised TX packet multiplexer between the link-layer packet sources (token/handshake generator, data path, and any added sources) and the PHY transmit interface. Arbitrates among NUM_CH valid/ready byte streams at packet granularity: a channel is granted at its SOP and keeps the grant until its EOP or cancel beat is accepted. Forwards beats through a 2-entry skid buffer, so the PHY link runs at full throughput with no combinational ready path from PHY to sources. Supersedes the fixed two-source, externally-selected TX mux.

## Interface
Parameters:
- NUM_CH, 2, number of source channels (2..8)
- DATA_W, 8, beat width in bits
- SEL_MODE, 0, 0 = external select via `sel`; 1 = round-robin arbitration
- SEL_W, $clog2(NUM_CH), width of `sel`

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- sel  in  SEL_W  channel select; used only when SEL_MODE=0
- in_sop  in  NUM_CH  per-channel start of packet
- in_eop  in  NUM_CH  per-channel end of packet
- in_valid  in  NUM_CH  per-channel beat valid
- in_ready  out  NUM_CH  per-channel beat accepted when valid&ready
- in_data  in  NUM_CH*DATA_W  channel i at bits [i*DATA_W +: DATA_W]
- in_cancel  in  NUM_CH  abort current packet; qualified by valid
- out_sop, out_eop, out_cancel  out  1  to PHY
- out_valid  out  1  to PHY
- out_ready  in  1  from PHY
- out_data  out  DATA_W  to PHY
- grant  out  NUM_CH  one-hot current owner; 0 when idle
- eop_done  out  1  out_valid & out_ready & (out_eop | out_cancel); combinational
- orphan_err  out  1  one-cycle pulse: a non-SOP beat was dropped while idle

## Operation
- Two-state arbiter FSM: IDLE, LOCKED. Reset -> IDLE.
- IDLE candidate: SEL_MODE=0 -> channel `sel` if its valid is set; SEL_MODE=1 -> first valid channel scanning upward from rr_ptr, wrapping modulo NUM_CH.
- IDLE, candidate beat has sop and buffer can accept: grant candidate in the same cycle. Beat accepted. If the beat also has eop or cancel, stay IDLE. Otherwise -> LOCKED.
- IDLE, candidate beat without sop: assert in_ready, discard the beat, pulse orphan_err, stay IDLE.
- LOCKED: only the granted channel sees in_ready. `sel` changes and other channels' valids are ignored.
- LOCKED -> IDLE when a beat with eop or cancel is accepted. A cancel beat is forwarded with out_cancel=1. Its out_eop is forced to 1.
- rr_ptr: on release, set to (owner+1) mod NUM_CH. Reset value 0.
- in_ready[i] = grant_eff[i] & ~skid_full, where grant_eff is the registered grant when LOCKED and the combinational candidate when IDLE (discard case excepted: ready is always 1).
- Skid buffer: main register drives out_*. Skid register captures a beat accepted while out_valid & ~out_ready. skid_full is registered.

## Timing
- Latency: a beat accepted in cycle t appears on out_* in cycle t+1.
- Throughput: 1 beat/cycle while out_ready=1.
- Back-to-back packets: EOP accepted in t; a new SOP from any channel can be accepted in t+1 (zero bubbles).
- out_* hold stable while out_valid & ~out_ready.
- out_ready deasserted for one cycle costs at most one in_ready-low cycle.
- Reset values: out_valid, out_sop, out_eop, out_cancel = 0; out_data = 0; grant = 0; in_ready = 0 while rst; orphan_err = 0; skid empty; FSM IDLE; rr_ptr = 0.
- Reset mid-packet: buffer flushed, lock released, out_valid=0 in the cycle after rst. No eop_done is generated for the truncated packet.
- sop & eop on the same beat: single-beat packet; FSM stays IDLE.
- sop on a beat while LOCKED: forwarded unchanged; not a new grant.
- A beat with in_valid=0 never changes state.

## Structure
- Package tx_mux_pkg: FSM state enum (ST_IDLE, ST_LOCKED) and SEL_MODE constants (MODE_EXT_SEL=0, MODE_RR=1).
- Sub-module tx_skid_buf: 2-entry valid/ready skid buffer with parameter WIDTH (DATA_W+3 payload: data, sop, eop, cancel).
- Arbiter, FSM and input mux live in tx_packet_mux.

## Test plan
- SEL_MODE=0, NUM_CH=2: ch1 sends 4-beat packet 0xA1..0xA4; `sel` flips to 0 after beat 2 -> all 4 beats on out, grant=2'b10 throughout, eop_done on beat 4.
- SEL_MODE=1, NUM_CH=3: all channels continuously valid with 2-beat packets -> grant order ch0, ch1, ch2, ch0; no idle cycle between packets.
- out_ready toggles 1,0,1,0 during a 6-beat packet -> the 6 beats arrive in order with none lost or duplicated; out_data stable while stalled.
- ch0 sends sop beat 0x11, then a beat 0x22 with cancel -> out shows 0x22 with out_cancel=1 and out_eop=1; FSM IDLE; next SOP accepted the following cycle.
- Idle, ch0 valid beat 0x55 without sop -> in_ready=1, orphan_err pulses once, out_valid stays 0.
- rst asserted on beat 3 of a 5-beat packet -> next cycle out_valid=0, grant=0; a fresh SOP is then granted normally.

Source files
------------

// File: rtl/tx_mux_pkg.sv
// Shared types and constants for the TX packet multiplexer.
package tx_mux_pkg;

  // Arbiter state: IDLE looks for a new owner, LOCKED forwards one packet.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Channel selection policy.
  localparam int MODE_EXT_SEL = 0;
  localparam int MODE_RR      = 1;

  // Extra payload bits carried alongside the data beat: cancel, eop, sop.
  localparam int CTRL_BITS = 3;

endpackage

// File: rtl/tx_skid_buf.sv
// Two-entry valid/ready skid buffer. The main register drives the output.
// The skid register absorbs the one beat that can arrive while the output
// is stalled. Upstream ready depends only on registered state.
module tx_skid_buf #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             main_vld_q;
  logic             skid_full_q;
  logic             take;
  logic             main_free;

  assign in_ready  = ~skid_full_q;
  assign out_valid = main_vld_q;
  assign out_data  = main_q;
  assign take      = in_valid & ~skid_full_q;
  assign main_free = ~main_vld_q | out_ready;

  // Main register refills from skid first; otherwise a stalled output parks
  // the incoming beat in the skid register.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q      <= '0;
      skid_q      <= '0;
      main_vld_q  <= 1'b0;
      skid_full_q <= 1'b0;
    end else if (main_free) begin
      if (skid_full_q) begin
        main_q      <= skid_q;
        main_vld_q  <= 1'b1;
        skid_full_q <= 1'b0;
      end else begin
        main_vld_q <= take;
        if (take) main_q <= in_data;
      end
    end else if (take) begin
      skid_q      <= in_data;
      skid_full_q <= 1'b1;
    end
  end

endmodule

// File: rtl/tx_packet_mux.sv
// Packet-granular TX multiplexer: picks one source channel at its SOP and
// holds the grant until that packet's EOP or cancel beat is accepted.
// Beats go through a skid buffer so PHY ready never reaches the sources
// combinationally.
module tx_packet_mux
  import tx_mux_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 8,
  parameter int SEL_MODE = 0,
  parameter int SEL_W    = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH-1:0]        in_sop,
  input  logic [NUM_CH-1:0]        in_eop,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_cancel,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic                     out_cancel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [NUM_CH-1:0]        grant,
  output logic                     eop_done,
  output logic                     orphan_err
);

  localparam int PW = DATA_W + CTRL_BITS;
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  arb_state_e        state_q, state_d;
  logic [SEL_W-1:0]  owner_q, owner_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]  cand_idx, scan_idx, cur_idx;
  logic              cand_vld;
  logic              beat_take;
  logic              discard;
  logic              orphan_q;

  logic              buf_ready;
  logic              buf_valid;
  logic [PW-1:0]     buf_din;
  logic [PW-1:0]     buf_dout;

  logic [DATA_W-1:0] ch_data [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch_data[g] = in_data[g*DATA_W +: DATA_W];
  end

  // Candidate owner while idle: external select, or first valid channel
  // scanning upward from rr_ptr (reverse loop so the nearest one wins).
  always_comb begin
    cand_idx = '0;
    cand_vld = 1'b0;
    scan_idx = '0;
    if (SEL_MODE == MODE_RR) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        scan_idx = SEL_W'((int'(rr_ptr_q) + i) % NUM_CH);
        if (in_valid[scan_idx]) begin
          cand_idx = scan_idx;
          cand_vld = 1'b1;
        end
      end
    end else begin
      if (int'(sel) < NUM_CH) begin
        cand_idx = sel;
        cand_vld = in_valid[sel];
      end
    end
  end

  // Arbiter next-state, per-channel ready and grant. An SOP candidate is
  // granted in the same cycle it is accepted; a non-SOP candidate while
  // idle is swallowed so it cannot block the channel.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    cur_idx   = owner_q;
    beat_take = 1'b0;
    discard   = 1'b0;
    in_ready  = '0;
    grant     = '0;
    if (state_q == ST_LOCKED) begin
      grant[owner_q]    = 1'b1;
      in_ready[owner_q] = buf_ready;
      beat_take         = in_valid[owner_q] & buf_ready;
    end else if (cand_vld) begin
      cur_idx = cand_idx;
      if (in_sop[cand_idx]) begin
        in_ready[cand_idx] = buf_ready;
        beat_take          = buf_ready;
        if (buf_ready) begin
          grant[cand_idx] = 1'b1;
          owner_d         = cand_idx;
          state_d         = ST_LOCKED;
        end
      end else begin
        in_ready[cand_idx] = 1'b1;
        discard            = 1'b1;
      end
    end
    // Packet end releases the lock, including single-beat packets.
    if (beat_take && (in_eop[cur_idx] || in_cancel[cur_idx])) begin
      state_d  = ST_IDLE;
      rr_ptr_d = (cur_idx == LAST_CH) ? '0 : cur_idx + 1'b1;
    end
    if (rst) begin
      in_ready  = '0;
      grant     = '0;
      beat_take = 1'b0;
      discard   = 1'b0;
    end
  end

  // Arbiter state, owner, round-robin pointer and orphan pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      orphan_q <= discard;
    end
  end

  // A cancel beat always closes the packet on the PHY side, so eop is forced.
  assign buf_valid = beat_take;
  assign buf_din   = {in_cancel[cur_idx],
                      in_eop[cur_idx] | in_cancel[cur_idx],
                      in_sop[cur_idx],
                      ch_data[cur_idx]};

  tx_skid_buf #(.WIDTH(PW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (buf_valid),
    .in_ready  (buf_ready),
    .in_data   (buf_din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_dout)
  );

  assign out_cancel = buf_dout[DATA_W+2];
  assign out_eop    = buf_dout[DATA_W+1];
  assign out_sop    = buf_dout[DATA_W];
  assign out_data   = buf_dout[DATA_W-1:0];
  assign eop_done   = out_valid & out_ready & (out_eop | out_cancel);
  assign orphan_err = orphan_q;

endmodule

// File: tb/tb_tx_packet_mux.sv
// Bench for tx_packet_mux: directed scenarios on an external-select
// instance, randomized backlogged traffic on a round-robin instance.
module tb_tx_packet_mux;

  typedef logic [10:0] beat_t;  // {cancel, eop, sop, data}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // External-select instance, 2 channels
  logic        e_rst;
  logic [0:0]  e_sel;
  logic [1:0]  e_sop, e_eop, e_valid, e_ready, e_cancel, e_grant;
  logic [15:0] e_data;
  logic        e_osop, e_oeop, e_ocan, e_ovalid, e_oready, e_eopd, e_orph;
  logic [7:0]  e_odata;

  tx_packet_mux #(.NUM_CH(2), .DATA_W(8), .SEL_MODE(0)) u_ext (
    .clk(clk), .rst(e_rst), .sel(e_sel),
    .in_sop(e_sop), .in_eop(e_eop), .in_valid(e_valid), .in_ready(e_ready),
    .in_data(e_data), .in_cancel(e_cancel),
    .out_sop(e_osop), .out_eop(e_oeop), .out_cancel(e_ocan), .out_valid(e_ovalid),
    .out_ready(e_oready), .out_data(e_odata),
    .grant(e_grant), .eop_done(e_eopd), .orphan_err(e_orph)
  );

  // Round-robin instance, 3 channels
  logic        r_rst;
  logic [1:0]  r_sel;
  logic [2:0]  r_sop, r_eop, r_valid, r_ready, r_cancel, r_grant;
  logic [23:0] r_data;
  logic        r_osop, r_oeop, r_ocan, r_ovalid, r_oready, r_eopd, r_orph;
  logic [7:0]  r_odata;

  tx_packet_mux #(.NUM_CH(3), .DATA_W(8), .SEL_MODE(1)) u_rr (
    .clk(clk), .rst(r_rst), .sel(r_sel),
    .in_sop(r_sop), .in_eop(r_eop), .in_valid(r_valid), .in_ready(r_ready),
    .in_data(r_data), .in_cancel(r_cancel),
    .out_sop(r_osop), .out_eop(r_oeop), .out_cancel(r_ocan), .out_valid(r_ovalid),
    .out_ready(r_oready), .out_data(r_odata),
    .grant(r_grant), .eop_done(r_eopd), .orphan_err(r_orph)
  );

  task automatic e_beat(input int c, input logic v, input logic s, input logic e,
                        input logic x, input logic [7:0] d);
    e_valid[c] = v; e_sop[c] = s; e_eop[c] = e; e_cancel[c] = x;
    e_data[c*8 +: 8] = d;
  endtask

  task automatic e_idle();
    e_valid = '0; e_sop = '0; e_eop = '0; e_cancel = '0; e_data = '0;
  endtask

  beat_t srcq [3][$];
  beat_t expq [$];
  beat_t bt, hold_b;
  int    rd [3];
  int    ptr, left, c, j, n, held, cyc;
  logic [7:0] hold_d;

  initial begin
    e_rst = 1'b1; r_rst = 1'b1; e_sel = '0; r_sel = '0;
    e_idle(); e_oready = 1'b1;
    r_valid = '0; r_sop = '0; r_eop = '0; r_cancel = '0; r_data = '0; r_oready = 1'b1;

    // Reset values, with a valid SOP presented to prove ready stays low.
    @(negedge clk);
    e_beat(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h99);
    @(negedge clk); #1;
    chk("rst_ovalid", e_ovalid, 0);
    chk("rst_odata", e_odata, 0);
    chk("rst_grant", e_grant, 0);
    chk("rst_ready", e_ready, 0);
    chk("rst_orph", e_orph, 0);
    chk("rst_rr_ovalid", r_ovalid, 0);
    @(negedge clk); e_rst = 1'b0; r_rst = 1'b0; e_idle();

    // External select: ch1 packet keeps its grant although sel flips to 0;
    // ch0 SOP waiting behind it is granted the cycle after the EOP.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) e_beat(1, 1'b1, k == 0, k == 3, 1'b0, 8'(8'hA1 + k));
      else       e_beat(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      e_beat(0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h0F);
      e_sel = (k < 2) ? 1'b1 : 1'b0;
      #1;
      if (k < 4) begin
        chk("sel_ready", e_ready, 2'b10);
        chk("sel_grant", e_grant, 2'b10);
      end else begin
        chk("b2b_ready", e_ready, 2'b01);
        chk("b2b_grant", e_grant, 2'b01);
      end
      if (k > 0) begin
        chk("sel_data", e_odata, 8'hA0 + k);
        chk("sel_valid", e_ovalid, 1);
        chk("sel_eopd", e_eopd, k == 4);
      end
    end
    @(negedge clk); e_idle(); #1;
    chk("b2b_out", {e_osop, e_oeop, e_odata}, {1'b1, 1'b1, 8'h0F});

    // Cancel: forwarded with cancel and forced eop; lock released at once.
    @(negedge clk); e_sel = 1'b0; e_beat(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11);
    @(negedge clk); e_beat(0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22); #1;
    chk("can_grant", e_grant, 2'b01);
    @(negedge clk); e_beat(0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h33); #1;
    chk("can_out", {e_ocan, e_oeop, e_odata}, {1'b1, 1'b1, 8'h22});
    chk("can_eopd", e_eopd, 1);
    chk("can_next_ready", e_ready, 2'b01);
    @(negedge clk); e_idle(); #1;
    chk("can_next_out", e_odata, 8'h33);
    @(negedge clk); #1;
    chk("drain", e_ovalid, 0);

    // Orphan beat while idle: accepted, dropped, one-cycle error pulse.
    @(negedge clk); e_beat(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55); #1;
    chk("orph_ready", e_ready, 2'b01);
    chk("orph_pre", e_orph, 0);
    @(negedge clk); e_idle(); #1;
    chk("orph_pulse", e_orph, 1);
    chk("orph_ovalid", e_ovalid, 0);
    @(negedge clk); #1;
    chk("orph_clear", e_orph, 0);
    chk("orph_ovalid2", e_ovalid, 0);

    // PHY stalls every other cycle during a 6-beat packet.
    j = 0; n = 0; held = 0; hold_d = '0;
    for (cyc = 0; cyc < 40 && n < 6; cyc++) begin
      @(negedge clk);
      if (j < 6) e_beat(0, 1'b1, j == 0, j == 5, 1'b0, 8'(8'hC0 + j));
      else       e_idle();
      e_oready = (cyc % 2 == 0);
      #1;
      if (held != 0) chk("stall_hold", {e_ovalid, e_odata}, {1'b1, hold_d});
      held = 0;
      if (e_ovalid && e_oready) begin
        chk("stall_data", e_odata, 8'hC0 + n);
        n++;
      end else if (e_ovalid) begin
        held = 1; hold_d = e_odata;
      end
      if (e_valid[0] && e_ready[0]) j++;
    end
    chk("stall_count", n, 6);
    @(negedge clk); e_idle(); e_oready = 1'b1;
    @(negedge clk);

    // Reset during beat 3 of a 5-beat packet.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      e_beat(0, 1'b1, k == 0, 1'b0, 1'b0, 8'(8'hD0 + k));
      if (k == 2) begin
        e_rst = 1'b1; #1;
        chk("mid_rst_ready", e_ready, 0);
        chk("mid_rst_grant", e_grant, 0);
      end
    end
    @(negedge clk); e_rst = 1'b0; e_idle(); #1;
    chk("mid_rst_ovalid", e_ovalid, 0);
    chk("mid_rst_grant2", e_grant, 0);
    chk("mid_rst_eopd", e_eopd, 0);
    @(negedge clk); e_sel = 1'b1; e_beat(1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hE1); #1;
    chk("post_rst_grant", e_grant, 2'b10);
    @(negedge clk); e_idle(); #1;
    chk("post_rst_out", {e_osop, e_oeop, e_odata}, {1'b1, 1'b1, 8'hE1});
    chk("post_rst_eopd", e_eopd, 1);

    // Randomized round-robin traffic. Every channel stays backlogged with
    // its SOP always valid, so the packet order is fixed by the RR rule:
    // after a release, the next owner is the first channel with packets
    // left, scanning upward from the previous owner + 1.
    for (int ch = 0; ch < 3; ch++) begin
      for (int p = 0; p < 5; p++) begin
        int len; logic can;
        len = $urandom_range(1, 4);
        can = ($urandom % 5) == 0;
        for (int b = 0; b < len; b++) begin
          bt = {(b == len - 1) & can, (b == len - 1) & ~can, b == 0, 8'($urandom)};
          srcq[ch].push_back(bt);
        end
      end
    end
    for (int ch = 0; ch < 3; ch++) rd[ch] = 0;
    ptr = 0; left = 15;
    while (left > 0) begin
      c = -1;
      for (int i = 0; i < 3; i++)
        if (c < 0 && rd[(ptr + i) % 3] < srcq[(ptr + i) % 3].size()) c = (ptr + i) % 3;
      do begin
        bt = srcq[c][rd[c]];
        rd[c]++;
        expq.push_back({bt[10], bt[10] | bt[9], bt[8], bt[7:0]});
      end while (!(bt[10] | bt[9]));
      ptr = (c + 1) % 3;
      left--;
    end

    held = 0; hold_b = '0;
    for (cyc = 0; cyc < 3000 && expq.size() > 0; cyc++) begin
      @(negedge clk);
      for (int ch = 0; ch < 3; ch++) begin
        if (srcq[ch].size() > 0) begin
          bt = srcq[ch][0];
          r_valid[ch] = bt[8] | (($urandom % 4) != 0);
          r_cancel[ch] = bt[10]; r_eop[ch] = bt[9]; r_sop[ch] = bt[8];
          r_data[ch*8 +: 8] = bt[7:0];
        end else begin
          r_valid[ch] = 1'b0; r_cancel[ch] = 1'b0; r_eop[ch] = 1'b0; r_sop[ch] = 1'b0;
        end
      end
      r_oready = ($urandom % 10) < 7;
      #1;
      chk("rr_ready_1hot", $countones(r_ready) <= 1, 1);
      for (int ch = 0; ch < 3; ch++)
        if (r_valid[ch] && r_ready[ch]) begin
          chk("rr_grant", r_grant, 3'b001 << ch);
          void'(srcq[ch].pop_front());
        end
      if (held != 0) chk("rr_hold", {r_ovalid, r_ocan, r_oeop, r_osop, r_odata}, {1'b1, hold_b});
      held = 0;
      if (r_ovalid && r_oready) begin
        bt = expq.pop_front();
        chk("rr_beat", {r_ocan, r_oeop, r_osop, r_odata}, bt);
        chk("rr_eopd", r_eopd, bt[9]);
      end else if (r_ovalid) begin
        held = 1; hold_b = {r_ocan, r_oeop, r_osop, r_odata};
        chk("rr_eopd_stall", r_eopd, 0);
      end
    end
    chk("rr_all_out", expq.size(), 0);
    chk("rr_no_orphan", r_orph, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
